// File: rtl/speed_ramp_controller_if.sv
// Request/status bundle between a speed requester and speed_ramp_controller.
// master: requester side (drives req/target/stop, observes status and speed).
// slave : controller side (drives ack, speed, div_rst, busy, done).
interface speed_ramp_controller_if #(
   parameter int SPEED_W = 20
);
   logic               req;
   logic [SPEED_W-1:0] target;
   logic               stop;
   logic               ack;
   logic [SPEED_W-1:0] speed;
   logic               div_rst;
   logic               busy;
   logic               done;

   modport master (
      output req, target, stop,
      input  ack, speed, div_rst, busy, done
   );

   modport slave (
      input  req, target, stop,
      output ack, speed, div_rst, busy, done
   );
endinterface

// File: rtl/speed_ramp_controller.sv
// Ramps the clock divider's speed toward a requested target in bounded steps.
// Latency: ack/done one edge after a sampled req; steps every STEP_CYCLES edges.
// Backpressure: req is only accepted in IDLE; the requester holds req until ack.
// Ports: clk, rst (async, active-high); bus.slave carries req/target/stop in and
// ack/speed/div_rst/busy/done out, all outputs registered.
module speed_ramp_controller #(
   parameter int SPEED_W     = 20,
   parameter int STEP        = 1000,
   parameter int STEP_CYCLES = 50000,
   parameter int MIN_SPEED   = 1,
   parameter int MAX_SPEED   = 1000000,
   parameter int INIT_SPEED  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   speed_ramp_controller_if.slave  bus
);

   localparam int                 CNT_W    = $clog2(STEP_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [SPEED_W:0]   STEP_V   = (SPEED_W+1)'(STEP);
   localparam logic [SPEED_W-1:0] MIN_V    = SPEED_W'(MIN_SPEED);
   localparam logic [SPEED_W-1:0] MAX_V    = SPEED_W'(MAX_SPEED);
   localparam logic [SPEED_W-1:0] INIT_V   = SPEED_W'(INIT_SPEED);

   typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SPEED_W-1:0] tgt_q, tgt_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_rst_q;

   logic [SPEED_W-1:0] tgt_clamped;
   logic               tgt_is_cur;
   logic               step_edge;
   logic               step_up;
   logic [SPEED_W:0]   diff;
   logic               step_hits;
   logic [SPEED_W-1:0] step_speed;

   // Request clamp and step arithmetic. Difference is one bit wider than the
   // speed so neither the subtraction nor the compare can wrap at the extremes.
   always_comb begin
      tgt_clamped = bus.target;
      if (bus.target < MIN_V) begin
         tgt_clamped = MIN_V;
      end else if (bus.target > MAX_V) begin
         tgt_clamped = MAX_V;
      end
      tgt_is_cur = (tgt_clamped == speed_q);

      step_edge = (cnt_q == CNT_LAST);
      step_up   = ({1'b0, tgt_q} > {1'b0, speed_q});
      diff      = step_up ? ({1'b0, tgt_q} - {1'b0, speed_q})
                          : ({1'b0, speed_q} - {1'b0, tgt_q});
      // A remaining gap of at most STEP is closed exactly, so no overshoot.
      step_hits = (diff <= STEP_V);
      if (step_hits) begin
         step_speed = tgt_q;
      end else if (step_up) begin
         // diff > STEP here, so STEP fits in SPEED_W bits and the add cannot wrap.
         step_speed = speed_q + STEP_V[SPEED_W-1:0];
      end else begin
         step_speed = speed_q - STEP_V[SPEED_W-1:0];
      end
   end

   // State register plus the registered outputs and datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tgt_q     <= INIT_V;
         speed_q   <= INIT_V;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tgt_q     <= tgt_d;
         speed_q   <= speed_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         // Divider leaves reset on the first edge after rst and stays out.
         div_rst_q <= 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req && !tgt_is_cur) begin
               state_d = RAMP;
            end
         end
         RAMP: begin
            // stop takes priority over a coincident step.
            if (bus.stop) begin
               state_d = IDLE;
            end else if (step_edge && step_hits) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      speed_d = speed_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.req) begin
               ack_d = 1'b1;
               tgt_d = tgt_clamped;
               if (tgt_is_cur) begin
                  done_d = 1'b1;
               end else begin
                  busy_d = 1'b1;
                  cnt_d  = '0;
               end
            end
         end
         RAMP: begin
            if (bus.stop) begin
               // Abort: speed holds, no done pulse.
               busy_d = 1'b0;
               cnt_d  = '0;
            end else if (step_edge) begin
               cnt_d   = '0;
               speed_d = step_speed;
               if (step_hits) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      endcase
   end

   assign bus.ack     = ack_q;
   assign bus.speed   = speed_q;
   assign bus.div_rst = div_rst_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: doc/speed_ramp_controller.md
# speed_ramp_controller

Sequencer that owns the `speed` input of the lab clock divider. It accepts new target speeds over a req/ack handshake and ramps the divider's `speed` toward the target in fixed steps at a fixed interval, so the divided output never jumps abruptly. It also generates the divider's reset and reports busy/done status to the requester.

## Interface
- `SPEED_W`, 20: width of speed values; matches the divider's `speed` port.
- `STEP`, 1000: maximum speed change per step; must be ≥1.
- `STEP_CYCLES`, 50000: clk cycles between steps; must be ≥2.
- `MIN_SPEED`, 1: lower clamp for targets.
- `MAX_SPEED`, 1000000: upper clamp for targets; must satisfy MIN_SPEED ≤ INIT_SPEED ≤ MAX_SPEED < 2^SPEED_W.
- `INIT_SPEED`, 1: speed after reset.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req` in 1: request. Held high by the requester until `ack`.
- `target` in SPEED_W: requested speed. Must be stable while `req` is high.
- `stop` in 1: abort the ramp in progress.
- `ack` out 1: one-cycle pulse when a request is accepted.
- `speed` out SPEED_W: drives the divider `speed` input.
- `div_rst` out 1: drives the divider `rst` input.
- `busy` out 1: high while ramping.
- `done` out 1: one-cycle pulse when `speed` reaches the target.

## Operation
- All outputs are registered.
- Reset values:
  - `speed` = INIT_SPEED
  - `div_rst` = 1
  - `ack` = 0, `busy` = 0, `done` = 0
  - state = IDLE
  - interval counter = 0
- `div_rst` deasserts on the first clk edge after `rst` falls and stays 0 until the next reset.
- States: IDLE and RAMP.
- IDLE:
  - `req` is sampled on each edge.
  - On acceptance, `target` is clamped to [MIN_SPEED, MAX_SPEED], stored as `tgt`, and `ack` = 1 for exactly one cycle.
  - If `tgt` == `speed`, `done` pulses in the same cycle as `ack` and the state remains IDLE.
  - Otherwise the state goes to RAMP, `busy` = 1, and the counter is cleared.
  - `stop` is ignored in IDLE.
- RAMP:
  - The counter increments each cycle. At count STEP_CYCLES-1 it wraps to 0 and a step occurs.
  - Step: `speed` moves toward `tgt` by min(STEP, |tgt − speed|). It never overshoots.
  - Difference and compare use SPEED_W+1-bit unsigned arithmetic, so no wrap-around occurs near 0 or 2^SPEED_W.
  - When a step makes `speed` == `tgt`: state → IDLE, `busy` = 0, and `done` = 1 for one cycle, all on that same edge.
  - `req` is not acknowledged in RAMP. The requester keeps `req` high; it is accepted on the first edge in IDLE.
  - `stop` high on an edge in RAMP: the state goes to IDLE, `speed` holds its current value, and `done` is not pulsed. If that edge is also a step edge, `stop` wins and no step occurs.
- Async `rst` mid-ramp returns everything to the reset values immediately. The pending target is discarded.

## Timing
- Request accepted on edge E:
  - `ack` is high during cycle E..E+1.
  - First step edge is E+STEP_CYCLES; subsequent steps follow every STEP_CYCLES edges.
- Total ramp length = ceil(|tgt − speed₀| / STEP) × STEP_CYCLES cycles after acceptance.
- `done` is coincident with the first cycle showing the final `speed` value.
- A new request can be accepted on the edge immediately after `done`, or after IDLE is re-entered via `stop`.
- The `speed` output changes only on step edges or on reset.

## Test plan
Parameters: STEP=10, STEP_CYCLES=4, MIN=1, MAX=100, INIT=1.

1. Reset, then release `rst`:
   - During reset: `speed`=1, `busy`=0, `ack`=0, `done`=0, `div_rst`=1.
   - `div_rst` → 0 one edge after release.
2. `req` with `target`=35 accepted at edge E:
   - `ack` pulses once.
   - `speed` = 11, 21, 31, 35 at edges E+4, E+8, E+12, E+16.
   - `done` pulses with 35; `busy` falls at E+16.
3. Clamping:
   - `target`=200 ramps to 100 (10 steps of 10 from 1, last step 9).
   - Then `target`=0 ramps down to 1 and stops there.
4. `target` equal to the current `speed`: `ack` and `done` pulse in the same cycle; `busy` stays 0.
5. Stop and busy-time requests:
   - Ramp toward 100; assert `stop` on a step edge at `speed`=21. Required: `speed` holds 21, no `done`, IDLE.
   - Second case: hold `req` high with `target`=50 during a ramp. Required: `ack` only after `done`.
6. Assert `rst` asynchronously mid-ramp: `speed`=1, `busy`=0, `div_rst`=1 without waiting for a clk edge.
